// File: rtl/pdp8_panel_pkg.sv
// Shared types and byte-tag constants for the PDP-8/I front-panel loader.
// Imported by pdp8_panel_loader and panel_key_timer.
package pdp8_panel_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOW_O,
    S_LOW_D,
    S_STOP_PULSE,
    S_WAIT_RUN,
    S_SETTLE,
    S_PULSE,
    S_GAP
  } state_e;

  typedef enum logic [2:0] {
    KEY_NONE,
    KEY_LOAD_ADDR,
    KEY_DEP,
    KEY_START,
    KEY_STOP
  } key_sel_e;

  localparam logic [7:0] LEADER     = 8'o200;
  localparam logic [7:0] CMD_START  = 8'h81;
  localparam logic [7:0] CMD_STOP   = 8'h82;
  localparam logic [7:0] TAG_MASK   = 8'hC0;
  localparam logic [7:0] TAG_ORIGIN = 8'h40;
  localparam logic [7:0] TAG_DATA   = 8'h00;
  localparam logic [7:0] FIELD_MASK = 8'hC7;
  localparam logic [7:0] FIELD_TAG  = 8'hC0;

  // Key vector order is {load_addr, dep, start, stop}.
  function automatic logic [3:0] key_onehot(input key_sel_e k);
    logic [3:0] v;
    v = 4'b0000;
    case (k)
      KEY_LOAD_ADDR: v = 4'b1000;
      KEY_DEP:       v = 4'b0100;
      KEY_START:     v = 4'b0010;
      KEY_STOP:      v = 4'b0001;
      default:       v = 4'b0000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/panel_key_timer.sv
// Times one console key: SETTLE (switch setup), PULSE (key high), GAP (idle).
// A go arriving in the cycle done is high chains the next key without a bubble.
module panel_key_timer
  import pdp8_panel_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES  = 8,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES    = 16
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       go_i,
  input  logic       skip_settle_i,
  input  key_sel_e   key_i,
  output logic [3:0] keys_o,
  output logic       done_o
);

  localparam logic [15:0] SETTLE_LEN = 16'(SETTLE_CYCLES);
  localparam logic [15:0] PULSE_LAST = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);

  state_e      phase_q, phase_d;
  logic [15:0] cnt_q, cnt_d;
  key_sel_e    sel_q, sel_d;
  logic [3:0]  keys_q, keys_d;

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      phase_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= KEY_NONE;
      keys_q  <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      keys_q  <= keys_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    keys_d  = keys_q;
    done_o  = 1'b0;
    case (phase_q)
      S_SETTLE: begin
        if (cnt_q == '0) begin
          phase_d = S_PULSE;
          cnt_d   = PULSE_LAST;
          keys_d  = key_onehot(sel_q);
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          phase_d = S_GAP;
          cnt_d   = GAP_LAST;
          keys_d  = '0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          phase_d = S_IDLE;
          done_o  = 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: phase_d = S_IDLE;
    endcase

    // Settle counts SETTLE_CYCLES down to zero so the key rises SETTLE_CYCLES+1 clocks after go.
    if (go_i && (phase_q == S_IDLE || done_o)) begin
      sel_d = key_i;
      if (skip_settle_i) begin
        phase_d = S_PULSE;
        cnt_d   = PULSE_LAST;
        keys_d  = key_onehot(key_i);
      end else begin
        phase_d = S_SETTLE;
        cnt_d   = SETTLE_LEN;
      end
    end
  end

  assign keys_o = keys_q;

endmodule

// File: rtl/pdp8_panel_loader.sv
// Decodes a BIN-style host byte stream into PDP-8/I console switch/key actions.
// Define PANEL_LOADER_CKSUM_EN to build the running frame-byte checksum on cksum.
module pdp8_panel_loader
  import pdp8_panel_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES  = 8,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES    = 16,
  parameter int unsigned STOP_TIMEOUT  = 4096
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic [7:0]  in_data,
  input  logic        in_strobe,
  output logic        in_ready,
  input  logic        run,
  output logic [11:0] sr,
  output logic [2:0]  ifsr,
  output logic [2:0]  dfsr,
  output logic        load_addr,
  output logic        dep,
  output logic        start,
  output logic        stop,
  output logic        busy,
  output logic        err,
  output logic [11:0] cksum
);

  localparam int unsigned TW = $clog2(STOP_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(STOP_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [2:0]  field_q, field_d;
  logic [11:0] origin_q, origin_d;
  logic [5:0]  hi_q, hi_d;
  logic [11:0] pend_q, pend_d;
  key_sel_e    pkey_q, pkey_d;
  logic        then_start_q, then_start_d;
  logic [11:0] sr_q, sr_d;
  logic [2:0]  fsr_q, fsr_d;
  logic        err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic        accept;
  logic [11:0] word;
  logic        tmr_go, tmr_skip, tmr_done;
  key_sel_e    tmr_key;
  logic [3:0]  keys;
  logic        launch, enter;
  key_sel_e    launch_key, seq_key;
  logic [11:0] launch_word, seq_word;

  assign in_ready = rst_l && (state_q inside {S_IDLE, S_LOW_O, S_LOW_D});
  assign accept   = in_strobe && in_ready;
  assign word     = {hi_q, in_data[5:0]};

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q      <= S_IDLE;
      field_q      <= '0;
      origin_q     <= '0;
      hi_q         <= '0;
      pend_q       <= '0;
      pkey_q       <= KEY_NONE;
      then_start_q <= 1'b0;
      sr_q         <= '0;
      fsr_q        <= '0;
      err_q        <= 1'b0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      field_q      <= field_d;
      origin_q     <= origin_d;
      hi_q         <= hi_d;
      pend_q       <= pend_d;
      pkey_q       <= pkey_d;
      then_start_q <= then_start_d;
      sr_q         <= sr_d;
      fsr_q        <= fsr_d;
      err_q        <= err_d;
      tmo_q        <= tmo_d;
    end
  end

  // S_SETTLE covers the whole SETTLE/PULSE/GAP walk, which the key timer tracks itself.
  always_comb begin
    state_d      = state_q;
    field_d      = field_q;
    origin_d     = origin_q;
    hi_d         = hi_q;
    pend_d       = pend_q;
    pkey_d       = pkey_q;
    then_start_d = then_start_q;
    sr_d         = sr_q;
    fsr_d        = fsr_q;
    err_d        = err_q;
    tmo_d        = tmo_q;
    tmr_go       = 1'b0;
    tmr_skip     = 1'b0;
    tmr_key      = KEY_NONE;
    launch       = 1'b0;
    launch_key   = KEY_NONE;
    launch_word  = '0;
    enter        = 1'b0;
    seq_key      = KEY_NONE;
    seq_word     = '0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (in_data == LEADER) begin
            state_d = S_IDLE;
          end else if (in_data == CMD_START) begin
            launch       = 1'b1;
            launch_key   = KEY_LOAD_ADDR;
            launch_word  = origin_q;
            then_start_d = 1'b1;
          end else if (in_data == CMD_STOP) begin
            launch       = 1'b1;
            launch_key   = KEY_STOP;
            then_start_d = 1'b0;
          end else if ((in_data & FIELD_MASK) == FIELD_TAG) begin
            field_d = in_data[5:3];
          end else if ((in_data & TAG_MASK) == TAG_ORIGIN) begin
            hi_d    = in_data[5:0];
            state_d = S_LOW_O;
          end else if ((in_data & TAG_MASK) == TAG_DATA) begin
            hi_d    = in_data[5:0];
            state_d = S_LOW_D;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOW_O, S_LOW_D: begin
        if (accept) begin
          if ((in_data & TAG_MASK) == TAG_DATA) begin
            launch       = 1'b1;
            launch_word  = word;
            then_start_d = 1'b0;
            if (state_q == S_LOW_O) begin
              origin_d   = word;
              launch_key = KEY_LOAD_ADDR;
            end else begin
              launch_key = KEY_DEP;
            end
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_SETTLE: begin
        if (tmr_done) begin
          if (then_start_q) begin
            then_start_d = 1'b0;
            tmr_go       = 1'b1;
            tmr_key      = KEY_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_STOP_PULSE: begin
        if (tmr_done) begin
          state_d = S_WAIT_RUN;
          tmo_d   = '0;
        end
      end
      S_WAIT_RUN: begin
        if (!run) begin
          enter    = 1'b1;
          seq_key  = pkey_q;
          seq_word = pend_q;
        end else if (tmo_q == TMO_LAST) begin
          err_d        = 1'b1;
          then_start_d = 1'b0;
          state_d      = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Interlock: a running CPU must be stopped before its address or memory is touched.
    if (launch) begin
      pend_d = launch_word;
      pkey_d = launch_key;
      if (run && (launch_key == KEY_LOAD_ADDR || launch_key == KEY_DEP)) begin
        state_d  = S_STOP_PULSE;
        tmr_go   = 1'b1;
        tmr_skip = 1'b1;
        tmr_key  = KEY_STOP;
      end else begin
        enter    = 1'b1;
        seq_key  = launch_key;
        seq_word = launch_word;
      end
    end

    if (enter) begin
      state_d = S_SETTLE;
      tmr_go  = 1'b1;
      tmr_key = seq_key;
      if (seq_key == KEY_LOAD_ADDR || seq_key == KEY_DEP) sr_d = seq_word;
      if (seq_key == KEY_LOAD_ADDR) fsr_d = field_q;
    end
  end

  panel_key_timer #(
    .PULSE_CYCLES (PULSE_CYCLES),
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .GAP_CYCLES   (GAP_CYCLES)
  ) u_key_timer (
    .clk          (clk),
    .rst_l        (rst_l),
    .go_i         (tmr_go),
    .skip_settle_i(tmr_skip),
    .key_i        (tmr_key),
    .keys_o       (keys),
    .done_o       (tmr_done)
  );

  assign {load_addr, dep, start, stop} = keys;
  assign sr   = sr_q;
  assign ifsr = fsr_q;
  assign dfsr = fsr_q;
  assign err  = err_q;
  assign busy = state_q inside {S_STOP_PULSE, S_WAIT_RUN, S_SETTLE};

`ifdef PANEL_LOADER_CKSUM_EN
  logic [11:0] cksum_q;
  logic        frame_byte;

  assign frame_byte = accept && (in_data[7:6] == 2'b00 ||
                                 (state_q == S_IDLE && in_data[7:6] == 2'b01));

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      cksum_q <= '0;
    end else if (frame_byte) begin
      cksum_q <= cksum_q + 12'(in_data);
    end
  end

  assign cksum = cksum_q;
`else
  assign cksum = '0;
`endif

endmodule

// File: tb/tb_pdp8_panel_loader.sv
// Directed self-checking bench for pdp8_panel_loader with hand-computed expectations.
// Timing constants assume the default parameters (settle 4, pulse 8, gap 16, timeout 4096).
module tb_pdp8_panel_loader;

  logic        clk;
  logic        rst_l;
  logic [7:0]  in_data;
  logic        in_strobe;
  logic        in_ready;
  logic        run;
  logic [11:0] sr;
  logic [2:0]  ifsr, dfsr;
  logic        load_addr, dep, start, stop;
  logic        busy, err;
  logic [11:0] cksum;
  logic [3:0]  keys;

  int total = 0;
  int bad   = 0;

  localparam logic [3:0] K_LOAD  = 4'b1000;
  localparam logic [3:0] K_DEP   = 4'b0100;
  localparam logic [3:0] K_START = 4'b0010;
  localparam logic [3:0] K_STOP  = 4'b0001;

  assign keys = {load_addr, dep, start, stop};

  pdp8_panel_loader dut (
    .clk      (clk),
    .rst_l    (rst_l),
    .in_data  (in_data),
    .in_strobe(in_strobe),
    .in_ready (in_ready),
    .run      (run),
    .sr       (sr),
    .ifsr     (ifsr),
    .dfsr     (dfsr),
    .load_addr(load_addr),
    .dep      (dep),
    .start    (start),
    .stop     (stop),
    .busy     (busy),
    .err      (err),
    .cksum    (cksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Presents one byte for exactly one accepting edge; returns on the negedge after it.
  task automatic applyStimulus(input logic [7:0] b);
    int n = 0;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) checkOutput("ready_wait", 32'(in_ready), 32'd1);
    in_data   = b;
    in_strobe = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_strobe = 1'b0;
  endtask

  // Waits for the next key, checks which one, its latency, sr at the rising edge and its width.
  task automatic seqCheck(input string tag, input logic [3:0] expKey, input logic [11:0] expSr,
                          input int expRise);
    int n = 0;
    int w = 0;
    while (keys == 4'b0000 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_key"}, 32'(keys), 32'(expKey));
    if (expRise >= 0) checkOutput({tag, "_rise"}, 32'(n), 32'(expRise));
    checkOutput({tag, "_sr"}, 32'(sr), 32'(expSr));
    while (keys != 4'b0000 && w < 100) begin
      @(negedge clk);
      w++;
    end
    checkOutput({tag, "_width"}, 32'(w), 32'd8);
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
    checkOutput({tag, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic doReset();
    rst_l = 1'b0;
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int n;
    logic sawKey;
    logic [11:0] expCk;

    rst_l     = 1'b0;
    in_data   = 8'h00;
    in_strobe = 1'b0;
    run       = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    checkOutput("rst_sr", 32'(sr), 32'd0);
    checkOutput("rst_ifsr", 32'(ifsr), 32'd0);
    checkOutput("rst_keys", 32'(keys), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_cksum", 32'(cksum), 32'd0);
    checkOutput("rst_ready", 32'(in_ready), 32'd0);
    rst_l = 1'b1;
    #1;
    checkOutput("rel_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Field 1, origin 0o0000
    applyStimulus(8'h80);
    applyStimulus(8'hC8);
    applyStimulus(8'h40);
    applyStimulus(8'h00);
    checkOutput("org0_busy", 32'(busy), 32'd1);
    checkOutput("org0_ready", 32'(in_ready), 32'd0);
    seqCheck("org0", K_LOAD, 12'o0000, 5);
    checkOutput("org0_ifsr", 32'(ifsr), 32'd1);
    checkOutput("org0_dfsr", 32'(dfsr), 32'd1);
    waitIdle("org0");

    // Origin 0o0100 then data 0o7777
    applyStimulus(8'h41);
    applyStimulus(8'h00);
    seqCheck("org100", K_LOAD, 12'o0100, 5);
    waitIdle("org100");
    applyStimulus(8'h3F);
    applyStimulus(8'h3F);
    seqCheck("dep7777", K_DEP, 12'o7777, 5);
    waitIdle("dep7777");
    checkOutput("dep7777_sr_hold", 32'(sr), 32'o7777);

    // Run interlock: stop first, then deposit once run drops
    run = 1'b1;
    applyStimulus(8'h00);
    applyStimulus(8'h05);
    seqCheck("ilk_stop", K_STOP, 12'o7777, 0);
    repeat (30) @(negedge clk);
    checkOutput("ilk_wait_busy", 32'(busy), 32'd1);
    checkOutput("ilk_wait_keys", 32'(keys), 32'd0);
    run = 1'b0;
    seqCheck("ilk_dep", K_DEP, 12'o0005, -1);
    waitIdle("ilk");
    checkOutput("ilk_err", 32'(err), 32'd0);

    // Run never falls: timeout sets err, no deposit
    run = 1'b1;
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    seqCheck("tmo_stop", K_STOP, 12'o0005, 0);
    n = 0;
    sawKey = 1'b0;
    while (!err && n < 6000) begin
      if (dep || load_addr) sawKey = 1'b1;
      @(negedge clk);
      n++;
    end
    checkOutput("tmo_err", 32'(err), 32'd1);
    checkOutput("tmo_nodep", 32'(sawKey), 32'd0);
    run = 1'b0;
    waitIdle("tmo");
    doReset();
    checkOutput("tmo_err_clr", 32'(err), 32'd0);

    // Bad low byte: err, no key, next frame still deposits
    applyStimulus(8'h02);
    applyStimulus(8'h45);
    checkOutput("bad_err", 32'(err), 32'd1);
    checkOutput("bad_busy", 32'(busy), 32'd0);
    sawKey = 1'b0;
    repeat (20) begin
      if (keys != 4'b0000) sawKey = 1'b1;
      @(negedge clk);
    end
    checkOutput("bad_nokey", 32'(sawKey), 32'd0);
    applyStimulus(8'h00);
    applyStimulus(8'h07);
    seqCheck("bad_dep", K_DEP, 12'o0007, 5);
    waitIdle("bad");
    doReset();

    // Origin 0o0200 then START: load_addr then start
    applyStimulus(8'h42);
    applyStimulus(8'h00);
    seqCheck("st_org", K_LOAD, 12'o0200, 5);
    checkOutput("st_ifsr", 32'(ifsr), 32'd0);
    waitIdle("st_org");
    applyStimulus(8'h81);
    seqCheck("st_load", K_LOAD, 12'o0200, 5);
    seqCheck("st_start", K_START, 12'o0200, 21);
    waitIdle("st");
`ifdef PANEL_LOADER_CKSUM_EN
    expCk = 12'h042;
`else
    expCk = 12'h000;
`endif
    checkOutput("st_cksum", 32'(cksum), 32'(expCk));

    // Byte while not ready is dropped; reset mid-pulse clears everything
    applyStimulus(8'h00);
    applyStimulus(8'h03);
    in_data   = 8'hC5;
    in_strobe = 1'b1;
    @(negedge clk);
    in_strobe = 1'b0;
    n = 0;
    while (!dep && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("mid_dep", 32'(dep), 32'd1);
    checkOutput("mid_sr", 32'(sr), 32'o0003);
    checkOutput("mid_err", 32'(err), 32'd0);
`ifdef PANEL_LOADER_CKSUM_EN
    expCk = 12'h045;
`else
    expCk = 12'h000;
`endif
    checkOutput("mid_cksum", 32'(cksum), 32'(expCk));
    rst_l = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_dep", 32'(dep), 32'd0);
    checkOutput("mid_rst_sr", 32'(sr), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_ready", 32'(in_ready), 32'd0);
    checkOutput("mid_rst_cksum", 32'(cksum), 32'd0);
    rst_l = 1'b1;
    #1;
    checkOutput("mid_rel_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
